regfile_rdmux_np: RTL and testbench

- Parametrised successor to the fixed 64-bit 32:1 register-read mux.
- Multi-port register file: one write port and NUM_RD independent registered read ports.
- Optional hardwired-zero register (XZR-style).
- Sits between decode and the execute-stage operand latches of the CPU datapath.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_rd_port.sv | 77 +++++++
 rtl/regfile_rdmux_np.sv | 72 +++++++
 tb/tb_regfile_rdmux_np.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and address-qualification helper for the
//               multi-port register file (regfile_rdmux_np).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default geometry of the integer register file.
    localparam int REGFILE_WIDTH  = 64;
    localparam int REGFILE_DEPTH  = 32;
    localparam int REGFILE_NUM_RD = 2;

    // An address names real, writable/readable storage only when it lies
    // inside the array and is not the hardwired-zero slot (DEPTH-1).
    // The same rule gates writes and qualifies reads, so both sides agree.
    function automatic logic addr_valid(
        input logic [31:0] addr,
        input int unsigned depth,
        input logic        zero_reg
    );
        return (addr < depth) && !(zero_reg && (addr == (depth - 1)));
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One registered read port of the register file: DEPTH:1
//               operand select with out-of-range / zero-register zeroing,
//               optional same-edge write forwarding, and a 1-cycle output
//               register that holds its data while the port is idle.
// Config      : REGFILE_BYPASS_EN - when defined, a same-edge write to the
//               address being read is forwarded to the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int DEPTH    = REGFILE_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    logic             rd_addr_ok;
    logic [WIDTH-1:0] sel_data;

    assign rd_addr_ok = addr_valid(32'(rd_addr), DEPTH, ZERO_REG != 0);

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;

    // Forward only to a real register: the zero slot and out-of-range
    // indices must keep reading 0 even while a write targets them.
    assign fwd_hit = wr_en && (wr_addr == rd_addr) &&
                     addr_valid(32'(wr_addr), DEPTH, ZERO_REG != 0);
`else
    // Write-port inputs only matter when forwarding is compiled in.
    logic bypass_unused;
    assign bypass_unused = ^{wr_en, wr_addr, wr_data};
`endif

    // Operand select: stored value, zero for invalid indices, or forwarded write data.
    always_comb begin
        sel_data = '0;
        if (rd_addr_ok) begin
            sel_data = mem[rd_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (fwd_hit) begin
            sel_data = wr_data;
        end
`endif
    end

    // Output register: capture on request, otherwise hold data and drop valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= sel_data;
            end
        end
    end

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/regfile_rdmux_np.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rdmux_np
// Description : Parametrised multi-port register file. One write port,
//               NUM_RD independent registered read ports (1-cycle latency),
//               optional hardwired-zero register at index DEPTH-1.
// Config      : REGFILE_BYPASS_EN - when defined, read ports forward a
//               same-edge write to the address they read (write-through);
//               otherwise they return the pre-write contents.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rdmux_np
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int DEPTH    = REGFILE_DEPTH,
    parameter int NUM_RD   = REGFILE_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_valid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    // Writes beyond the array or into the zero slot are silently dropped,
    // which also keeps the zero slot at its reset value of 0.
    assign wr_ok = wr_en && addr_valid(32'(wr_addr), DEPTH, ZERO_REG != 0);

    // Storage array: async clear, single write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // One independent read port per requester; all see the same storage.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        regfile_rd_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_rd_port (
            .clk      (clk),
            .reset_n  (reset_n),
            .mem      (mem),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_en    (rd_en[p]),
            .rd_addr  (rd_addr[p*AW +: AW]),
            .rd_data  (rd_data[p*WIDTH +: WIDTH]),
            .rd_valid (rd_valid[p])
        );
    end

endmodule : regfile_rdmux_np
`default_nettype wire

// File: tb/tb_regfile_rdmux_np.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_rdmux_np
// Description : Scoreboard bench for regfile_rdmux_np. Three instances share
//               one stimulus stream: default (ZERO_REG=1, DEPTH=32), no zero
//               register (ZERO_REG=0), and non-power-of-two (DEPTH=24).
// Config      : REGFILE_BYPASS_EN selects the expected same-edge result.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_rdmux_np;

    localparam logic [63:0] ONES = '1;
`ifdef REGFILE_BYPASS_EN
    localparam logic [63:0] HAZ_EXP = 64'h22;
    localparam logic [63:0] ZR_NZ   = 64'h77;
`else
    localparam logic [63:0] HAZ_EXP = 64'h11;
    localparam logic [63:0] ZR_NZ   = ONES;
`endif

    typedef struct {
        int          inst;
        int          port;
        logic [63:0] d;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [1:0]   rd_en;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data_a, rd_data_b, rd_data_c;
    logic [1:0]   rd_valid_a, rd_valid_b, rd_valid_c;

    logic [127:0] mdata  [3];
    logic [1:0]   mvalid [3];
    logic [63:0]  last_d [3][2];

    exp_t exp_q[$];
    int   total;
    int   bad;

    regfile_rdmux_np u_dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    regfile_rdmux_np #(.ZERO_REG(0)) u_nz (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    regfile_rdmux_np #(.DEPTH(24)) u_d24 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c)
    );

    assign mdata[0]  = rd_data_a;
    assign mdata[1]  = rd_data_b;
    assign mdata[2]  = rd_data_c;
    assign mvalid[0] = rd_valid_a;
    assign mvalid[1] = rd_valid_b;
    assign mvalid[2] = rd_valid_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: async reset clears everything; otherwise compare each port every negedge.
    always begin
        @(negedge clk or negedge reset_n);
        if (!reset_n) begin
            #1;
            exp_q.delete();
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    last_d[i][p] = '0;
                    chk($sformatf("reset_valid i%0d p%0d", i, p), 64'(mvalid[i][p]), 64'd0);
                    chk($sformatf("reset_data i%0d p%0d", i, p), mdata[i][p*64 +: 64], 64'd0);
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    logic want;
                    exp_t ex;
                    want = (exp_q.size() > 0) && (exp_q[0].inst == i) && (exp_q[0].port == p);
                    chk($sformatf("valid i%0d p%0d", i, p), 64'(mvalid[i][p]), 64'(want));
                    if (want) begin
                        ex = exp_q.pop_front();
                        chk($sformatf("data i%0d p%0d", i, p), mdata[i][p*64 +: 64], ex.d);
                        last_d[i][p] = ex.d;
                    end else begin
                        chk($sformatf("hold i%0d p%0d", i, p), mdata[i][p*64 +: 64], last_d[i][p]);
                    end
                end
            end
            if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL leftover: got %0d unconsumed expected 0", exp_q.size());
                exp_q.delete();
            end
        end
    end

    // One clock of stimulus; expected read data given per instance (a,b,c).
    task automatic step(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [63:0] a0, input logic [63:0] a1,
                        input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] c0, input logic [63:0] c1);
        logic [63:0] e [3][2];
        e[0][0] = a0; e[0][1] = a1;
        e[1][0] = b0; e[1][1] = b1;
        e[2][0] = c0; e[2][1] = c1;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = {ra1, ra0};
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (re[p]) exp_q.push_back('{i, p, e[i][p]});
            end
        end
        #1;
        wr_en = 1'b0;
        rd_en = 2'b00;
    endtask

    task automatic step_all(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                            input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                            input logic [63:0] x0, input logic [63:0] x1);
        step(we, wa, wd, re, ra0, ra1, x0, x1, x0, x1, x0, x1);
    endtask

    task automatic idle(input int n);
        repeat (n) step_all(1'b0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
    endtask

    // DEPTH=24 instance: r23 is its zero register, r24+ are out of range.
    function automatic logic [63:0] e24(input int k);
        return (k < 23) ? (64'd1 << k) : 64'd0;
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        idle(1);

        // Asynchronous reset between edges wipes r5 and the outputs.
        step_all(1'b1, 5'd5, 64'hDEAD, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        step_all(1'b0, 5'd0, 64'd0, 2'b01, 5'd5, 5'd0, 64'hDEAD, 64'd0);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        idle(1);
        step_all(1'b0, 5'd0, 64'd0, 2'b11, 5'd5, 5'd5, 64'd0, 64'd0);

        // Walking-one fill, then swept reads on both ports.
        for (int i = 0; i <= 30; i++) begin
            step_all(1'b1, 5'(i), 64'd1 << i, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        end
        for (int i = 0; i <= 30; i++) begin
            step(1'b0, 5'd0, 64'd0, 2'b11, 5'(i), 5'(30 - i),
                 64'd1 << i, 64'd1 << (30 - i),
                 64'd1 << i, 64'd1 << (30 - i),
                 e24(i), e24(30 - i));
            if (i % 8 == 7) idle(1);
        end

        // Zero register: write all-ones to r31.
        step_all(1'b1, 5'd31, ONES, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        step(1'b0, 5'd0, 64'd0, 2'b11, 5'd31, 5'd31, 64'd0, 64'd0, ONES, ONES, 64'd0, 64'd0);
        // Same-edge write to r31 never forwards into the zero register.
        step(1'b1, 5'd31, 64'h77, 2'b01, 5'd31, 5'd0, 64'd0, 64'd0, ZR_NZ, 64'd0, 64'd0, 64'd0);

        // Same-edge write/read hazard on r7.
        step_all(1'b1, 5'd7, 64'h11, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        step_all(1'b1, 5'd7, 64'h22, 2'b01, 5'd7, 5'd0, HAZ_EXP, 64'd0);
        step_all(1'b0, 5'd0, 64'd0, 2'b10, 5'd0, 5'd7, 64'd0, 64'h22);

        // Both ports read r3 together, then hold while r3 is rewritten.
        step_all(1'b1, 5'd3, 64'hABCD, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        step_all(1'b0, 5'd0, 64'd0, 2'b11, 5'd3, 5'd3, 64'hABCD, 64'hABCD);
        step_all(1'b1, 5'd3, 64'h1234, 2'b00, 5'd3, 5'd3, 64'd0, 64'd0);
        idle(2);
        step_all(1'b0, 5'd0, 64'd0, 2'b11, 5'd3, 5'd3, 64'h1234, 64'h1234);

        // Write to r25: real register for DEPTH=32, dropped for DEPTH=24.
        step_all(1'b1, 5'd25, 64'h5555, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        step(1'b0, 5'd0, 64'd0, 2'b11, 5'd25, 5'd0,
             64'h5555, 64'd1, 64'h5555, 64'd1, 64'd0, 64'd1);
        step(1'b0, 5'd0, 64'd0, 2'b11, 5'd22, 5'd23,
             64'd1 << 22, 64'd1 << 23, 64'd1 << 22, 64'd1 << 23, 64'd1 << 22, 64'd0);

        // Reset while a read is in flight discards it.
        step_all(1'b0, 5'd0, 64'd0, 2'b11, 5'd0, 5'd0, 64'd1, 64'd1);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        idle(2);
        step_all(1'b0, 5'd0, 64'd0, 2'b11, 5'd0, 5'd22, 64'd0, 64'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000ns");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_rdmux_np
`default_nettype wire
